kbd_scancode_decoder: RTL

//  Consumes the byte stream from the PS/2 receiver FIFO (valid/ready pop) and decodes
//  PS/2 scan-code set 2: E0 extended prefix, F0 break prefix, typematic repeat.

---
 rtl/kbd_scancode_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/kbd_scancode_decoder.sv
// PS/2 scan-code set 2 decoder.
// Pops bytes from the receiver FIFO, tracks E0/F0 prefixes, and holds the
// last make code with its ASCII value. It also counts new presses and frame errors.
// Optional feature: define KBD_SHIFT_EN to track the shift keys (0x12/0x59)
// and map letters to uppercase while shift is held.
module kbd_scancode_decoder #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             frame_err,
  output logic [7:0]       scan_code,
  output logic             ext,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic             evt_valid,
  output logic             evt_break,
  output logic [CNT_W-1:0] press_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {S_FETCH = 1'b0, S_DECODE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       live_q;     // holds off the first pop until one clock after reset
  logic [7:0] byte_q;
  logic       ext_f, brk_f;
  logic       pop, dec;
  logic       is_e0, is_f0, is_shift, same_key;
  logic [7:0] ascii_new;

  // Set-2 make code to lowercase ASCII; unmapped codes give 0x00
  function automatic logic [7:0] lut(input logic [7:0] c);
    case (c)
      8'h1C: lut = 8'h61; 8'h32: lut = 8'h62; 8'h21: lut = 8'h63; 8'h23: lut = 8'h64;
      8'h24: lut = 8'h65; 8'h2B: lut = 8'h66; 8'h34: lut = 8'h67; 8'h33: lut = 8'h68;
      8'h43: lut = 8'h69; 8'h3B: lut = 8'h6A; 8'h42: lut = 8'h6B; 8'h4B: lut = 8'h6C;
      8'h3A: lut = 8'h6D; 8'h31: lut = 8'h6E; 8'h44: lut = 8'h6F; 8'h4D: lut = 8'h70;
      8'h15: lut = 8'h71; 8'h2D: lut = 8'h72; 8'h1B: lut = 8'h73; 8'h2C: lut = 8'h74;
      8'h3C: lut = 8'h75; 8'h2A: lut = 8'h76; 8'h1D: lut = 8'h77; 8'h22: lut = 8'h78;
      8'h35: lut = 8'h79; 8'h1A: lut = 8'h7A;
      8'h45: lut = 8'h30; 8'h16: lut = 8'h31; 8'h1E: lut = 8'h32; 8'h26: lut = 8'h33;
      8'h25: lut = 8'h34; 8'h2E: lut = 8'h35; 8'h36: lut = 8'h36; 8'h3D: lut = 8'h37;
      8'h3E: lut = 8'h38; 8'h46: lut = 8'h39;
      8'h29: lut = 8'h20; 8'h5A: lut = 8'h0D;
      default: lut = 8'h00;
    endcase
  endfunction

  assign pop      = rx_ready && rx_valid;
  assign dec      = (state_q == S_DECODE);
  assign is_e0    = (byte_q == 8'hE0);
  assign is_f0    = (byte_q == 8'hF0);
  assign same_key = (byte_q == scan_code) && (ext_f == ext);

`ifdef KBD_SHIFT_EN
  logic shift_q;

  assign is_shift = (byte_q == 8'h12) || (byte_q == 8'h59);

  // Shift state: a make sets it and a break clears it. Any E0 prefix is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             shift_q <= 1'b0;
    else if (dec && !is_e0 && !is_f0 && is_shift) shift_q <= !brk_f;
  end

  // ASCII for a new make. Letters are uppercased while shift is held.
  always_comb begin
    ascii_new = ext_f ? 8'h00 : lut(byte_q);
    if (shift_q && ascii_new >= 8'h61 && ascii_new <= 8'h7A)
      ascii_new = ascii_new - 8'h20;
  end
`else
  assign is_shift = 1'b0;

  // ASCII for a new make. Extended codes never map to ASCII.
  always_comb begin
    ascii_new = ext_f ? 8'h00 : lut(byte_q);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next state: fetch a byte, then spend one cycle decoding it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (pop) state_d = S_DECODE;
      S_DECODE: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // FSM outputs
  always_comb begin
    rx_ready = (state_q == S_FETCH) && live_q;
  end

  // Byte latch on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   byte_q <= 8'h00;
    else if (pop) byte_q <= rx_data;
  end

  // Decode: update prefix flags, key state, press count and the event strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      scan_code <= 8'h00;
      ext       <= 1'b0;
      ascii     <= 8'h00;
      key_down  <= 1'b0;
      press_cnt <= '0;
      evt_valid <= 1'b0;
      evt_break <= 1'b0;
    end else begin
      evt_valid <= 1'b0;
      evt_break <= 1'b0;
      if (dec) begin
        if (is_e0) begin
          ext_f <= 1'b1;
        end else if (is_f0) begin
          brk_f <= 1'b1;
        end else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
          if (!is_shift) begin
            evt_valid <= 1'b1;
            evt_break <= brk_f;
            if (brk_f) begin
              if (same_key) key_down <= 1'b0;
            end else if (!(key_down && same_key)) begin
              // A new press. A typematic repeat of the held key skips this branch.
              scan_code <= byte_q;
              ext       <= ext_f;
              ascii     <= ascii_new;
              key_down  <= 1'b1;
              press_cnt <= press_cnt + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Frame error counter saturates at all-ones and is independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_cnt <= '0;
    else if (frame_err && ~&err_cnt)   err_cnt <= err_cnt + ERR_W'(1);
  end

endmodule
